mdv_issue_ctrl: RTL and testbench

// - Initiator side of the multiply/divide unit (HI/LO) interface: sits in the pipeline between E-stage

---
 rtl/mdv_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_mdv_issue_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mdv_issue_ctrl.sv
// Issue/stall controller for the HI/LO multiply-divide unit: drives start/op, stalls D, checks busy latency.
// Optional performance counters are enabled by defining MDV_PERF_EN.
package databus;
   typedef enum logic [3:0] {
      MDV_none,
      MDV_mult,
      MDV_multu,
      MDV_div,
      MDV_divu,
      MDV_mfhi,
      MDV_mflo,
      MDV_mthi,
      MDV_mtlo
   } MDVOPTION;
endpackage

module mdv_issue_ctrl
   import databus::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     d_valid,
   input  MDVOPTION d_mdvop,
   input  logic     e_valid,
   input  logic     e_flush,
   input  MDVOPTION e_mdvop,
   input  logic     mdv_busy,
   output logic     mdv_start,
   output MDVOPTION mdv_op,
   output logic     stall_d,
   output logic     proto_err
`ifdef MDV_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_md_issued
`endif
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               e_go;
   logic               inflight;
   logic [CNT_W-1:0]   lat_sel;

   function automatic logic is_md(input MDVOPTION op);
      return (op == MDV_mult) || (op == MDV_multu) || (op == MDV_div) || (op == MDV_divu);
   endfunction

   function automatic logic is_mdv(input MDVOPTION op);
      return op != MDV_none;
   endfunction

   // BUSY with cnt==0 and busy low is the retiring cycle: it no longer holds D.
   assign inflight = (state_q == ST_BUSY) && ((cnt_q != '0) || mdv_busy);
   assign e_go     = e_valid && !e_flush && !reset;
   assign lat_sel  = ((e_mdvop == MDV_mult) || (e_mdvop == MDV_multu)) ? CNT_W'(MUL_LAT)
                                                                        : CNT_W'(DIV_LAT);

   always_comb begin
      mdv_op    = e_go ? e_mdvop : MDV_none;
      mdv_start = e_go && is_md(e_mdvop);
      stall_d   = !reset && d_valid && is_mdv(d_mdvop) && (mdv_busy || mdv_start || inflight);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (mdv_busy) err_d = 1'b1;
            if (mdv_start) begin
               state_d = ST_BUSY;
               cnt_d   = lat_sel;
            end
         end
         ST_BUSY: begin
            if (mdv_busy != (cnt_q != '0)) err_d = 1'b1;
            if (mdv_start) begin
               // A start while still in flight means an md op slipped past the stall.
               if (inflight) err_d = 1'b1;
               cnt_d = lat_sel;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!mdv_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign proto_err = err_q;

`ifdef MDV_PERF_EN
   logic [31:0] perf_stall_q, perf_issued_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_q  <= '0;
         perf_issued_q <= '0;
      end else begin
         if (stall_d)   perf_stall_q  <= perf_stall_q + 32'd1;
         if (mdv_start) perf_issued_q <= perf_issued_q + 32'd1;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_md_issued    = perf_issued_q;
`endif

endmodule

// File: tb/tb_mdv_issue_ctrl.sv
// Directed bench for mdv_issue_ctrl with a simple MDV busy model of configurable latency.
// Define MDV_PERF_EN to also check the performance counters.
module tb_mdv_issue_ctrl;
   import databus::*;

   logic     clk = 1'b0;
   logic     reset = 1'b1;
   logic     d_valid = 1'b0;
   MDVOPTION d_mdvop = MDV_none;
   logic     e_valid = 1'b0;
   logic     e_flush = 1'b0;
   MDVOPTION e_mdvop = MDV_none;
   logic     mdv_busy;
   logic     mdv_start;
   MDVOPTION mdv_op;
   logic     stall_d;
   logic     proto_err;
`ifdef MDV_PERF_EN
   logic [31:0] perf_stall_cycles, perf_md_issued;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int mul_lat_m = 5;
   int div_lat_m = 10;
   logic [4:0] mcnt;

   mdv_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset),
      .d_valid(d_valid), .d_mdvop(d_mdvop),
      .e_valid(e_valid), .e_flush(e_flush), .e_mdvop(e_mdvop),
      .mdv_busy(mdv_busy), .mdv_start(mdv_start), .mdv_op(mdv_op),
      .stall_d(stall_d), .proto_err(proto_err)
`ifdef MDV_PERF_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_md_issued(perf_md_issued)
`endif
   );

   always #5 clk = ~clk;

   // MDV model: busy for the configured number of cycles after each start.
   always @(posedge clk) begin
      if (reset) mcnt <= '0;
      else if (mdv_start)
         mcnt <= ((mdv_op == MDV_mult) || (mdv_op == MDV_multu)) ? 5'(mul_lat_m) : 5'(div_lat_m);
      else if (mcnt != '0) mcnt <= mcnt - 5'd1;
   end
   assign mdv_busy = (mcnt != '0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic ev, input logic ef, input MDVOPTION eop,
                        input logic dv, input MDVOPTION dop);
      e_valid = ev;
      e_flush = ef;
      e_mdvop = eop;
      d_valid = dv;
      d_mdvop = dop;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b1, 1'b0, MDV_div, 1'b1, MDV_mflo);
      #1;
      chk("rst_start", 32'(mdv_start), 32'd0);
      chk("rst_stall", 32'(stall_d), 32'd0);
      chk("rst_op", 32'(mdv_op), 32'(MDV_none));
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, MDV_none, 1'b0, MDV_none);
      #1;
      chk("rst_err", 32'(proto_err), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      MDVOPTION exp_op;
      @(negedge clk);
      do_reset();

      // mult in E with mfhi in D
      for (int c = 0; c <= 7; c++) begin
         if (c == 0)      drive(1'b1, 1'b0, MDV_mult, 1'b1, MDV_mfhi);
         else if (c <= 6) drive(1'b0, 1'b0, MDV_none, 1'b1, MDV_mfhi);
         else             drive(1'b1, 1'b0, MDV_mfhi, 1'b0, MDV_none);
         exp_op = (c == 0) ? MDV_mult : ((c == 7) ? MDV_mfhi : MDV_none);
         #1;
         chk("t1_start", 32'(mdv_start), 32'(c == 0));
         chk("t1_stall", 32'(stall_d), 32'(c <= 5));
         chk("t1_op", 32'(mdv_op), 32'(exp_op));
         chk("t1_err", 32'(proto_err), 32'd0);
         @(negedge clk);
      end

      // div with mflo in D, then a fresh start once the window closes
      for (int c = 0; c <= 13; c++) begin
         if (c == 0)       drive(1'b1, 1'b0, MDV_div, 1'b1, MDV_mflo);
         else if (c <= 11) drive(1'b0, 1'b0, MDV_none, 1'b1, MDV_mflo);
         else if (c == 12) drive(1'b1, 1'b0, MDV_div, 1'b0, MDV_none);
         else              drive(1'b0, 1'b0, MDV_none, 1'b0, MDV_none);
         #1;
         chk("t2_start", 32'(mdv_start), 32'((c == 0) || (c == 12)));
         if (c <= 11) chk("t2_stall", 32'(stall_d), 32'(c <= 10));
         chk("t2_err", 32'(proto_err), 32'd0);
         @(negedge clk);
      end
      do_reset();

      // MDV drops busy one cycle early
      mul_lat_m = 4;
      for (int c = 0; c <= 9; c++) begin
         if (c == 0) drive(1'b1, 1'b0, MDV_mult, 1'b0, MDV_none);
         else        drive(1'b0, 1'b0, MDV_none, 1'b0, MDV_none);
         #1;
         if (c == 5 || c == 6 || c == 9) chk("t3_err", 32'(proto_err), 32'(c >= 6));
         @(negedge clk);
      end
      mul_lat_m = 5;
      do_reset();

      // flushed mult in E
      drive(1'b1, 1'b1, MDV_mult, 1'b1, MDV_mfhi);
      #1;
      chk("t4_start", 32'(mdv_start), 32'd0);
      chk("t4_op", 32'(mdv_op), 32'(MDV_none));
      chk("t4_stall", 32'(stall_d), 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, MDV_none, 1'b1, MDV_mfhi);
      #1;
      chk("t4_stall_idle", 32'(stall_d), 32'd0);
      chk("t4_err", 32'(proto_err), 32'd0);
      @(negedge clk);
      do_reset();

      // reset in the middle of a div
      for (int c = 0; c <= 5; c++) begin
         reset = (c == 3);
         if (c == 0) drive(1'b1, 1'b0, MDV_div, 1'b1, MDV_mflo);
         else        drive(1'b0, 1'b0, MDV_none, 1'b1, MDV_mflo);
         #1;
         chk("t5_stall", 32'(stall_d), 32'(c <= 2));
         chk("t5_start", 32'(mdv_start), 32'(c == 0));
         if (c >= 4) chk("t5_err", 32'(proto_err), 32'd0);
         @(negedge clk);
      end
      reset = 1'b0;
      do_reset();

      // multu back-to-back with the retiring cycle
      for (int c = 0; c <= 12; c++) begin
         if (c == 0 || c == 6) drive(1'b1, 1'b0, MDV_multu, 1'b1, MDV_mfhi);
         else                  drive(1'b0, 1'b0, MDV_none, 1'b1, MDV_mfhi);
         #1;
         chk("t6_start", 32'(mdv_start), 32'((c == 0) || (c == 6)));
         chk("t6_stall", 32'(stall_d), 32'(c <= 11));
         chk("t6_err", 32'(proto_err), 32'd0);
`ifdef MDV_PERF_EN
         if (c == 7)  chk("t6_perf_issued", perf_md_issued, 32'd2);
         if (c == 12) chk("t6_perf_stall", perf_stall_cycles, 32'd12);
`endif
         @(negedge clk);
      end
      do_reset();

      // md op bypassing the stall while in flight
      for (int c = 0; c <= 3; c++) begin
         if (c == 0 || c == 2) drive(1'b1, 1'b0, MDV_mult, 1'b0, MDV_none);
         else                  drive(1'b0, 1'b0, MDV_none, 1'b0, MDV_none);
         #1;
         if (c == 2) chk("t7_start", 32'(mdv_start), 32'd1);
         if (c >= 2) chk("t7_err", 32'(proto_err), 32'(c == 3));
         @(negedge clk);
      end
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
